// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: reset PC, word size, sequencer FSM encoding.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: PC/hazard/redirect/imem inputs and PC-register controls.
interface fetch_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      pc_cur;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic             imem_ready;
  logic [31:0]      npc;
  logic             pc_en;
  logic             ifid_en;
  logic             addr_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output pc_cur, stall, redirect_valid, redirect_target, imem_ready,
    input  npc, pc_en, ifid_en, addr_err, stall_cnt
  );

  modport slave (
    input  pc_cur, stall, redirect_valid, redirect_target, imem_ready,
    output npc, pc_en, ifid_en, addr_err, stall_cnt
  );
endinterface

// File: rtl/fetch_sequencer_redirect_buf.sv
// One-entry redirect target holder: set/overwrite wins over clear, misalign flag on input.
module redirect_buf
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set,
  input  logic            clear,
  input  logic [XLEN-1:0] target,
  output logic            valid,
  output logic [XLEN-1:0] target_q,
  output logic            misalign
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid    <= 1'b0;
      target_q <= '0;
    end else if (set) begin
      valid    <= 1'b1;
      target_q <= word_align(target);
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

  assign misalign = |target[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/WAIT FSM, next-PC select, enables, stall counter.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic             sample_c;
  logic             pc_en_c;
  logic [31:0]      npc_c;
  logic             addr_err_c;
  logic             buf_valid;
  logic [31:0]      buf_target;
  logic             misalign;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!bus.imem_ready) state_d = ST_WAIT;
      ST_WAIT: if (bus.imem_ready)  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Redirects from ID are only trusted when the hazard unit is not holding ID.
  always_comb begin
    sample_c   = 1'b0;
    pc_en_c    = 1'b0;
    addr_err_c = 1'b0;
    npc_c      = RESET_PC;
    if (reset && state_q != ST_BOOT) begin
      sample_c   = bus.redirect_valid && !bus.stall;
      pc_en_c    = (state_q == ST_RUN) && bus.imem_ready && !bus.stall;
      addr_err_c = sample_c && misalign;
      if (sample_c)       npc_c = word_align(bus.redirect_target);
      else if (buf_valid) npc_c = buf_target;
      else                npc_c = word_align(bus.pc_cur + 32'(WORD_BYTES));
    end
  end

  redirect_buf u_redirect_buf (
    .clk      (clk),
    .reset    (reset),
    .set      (sample_c && !pc_en_c),
    .clear    (pc_en_c),
    .target   (bus.redirect_target),
    .valid    (buf_valid),
    .target_q (buf_target),
    .misalign (misalign)
  );

  // Counts lost fetch cycles after BOOT; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!pc_en_c && state_q != ST_BOOT && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.npc       = npc_c;
  assign bus.pc_en     = pc_en_c;
  assign bus.ifid_en   = pc_en_c;
  assign bus.addr_err  = addr_err_c;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register in the loop.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_reg;
  logic        ovr_en;
  logic [31:0] ovr_pc;
  int          total = 0;
  int          bad   = 0;

  fetch_sequencer_if #(.CNT_W(16)) bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset)          pc_reg <= 32'h0000_3000;
    else if (bus.pc_en)  pc_reg <= bus.npc;
  end

  assign bus.pc_cur = ovr_en ? ovr_pc : pc_reg;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.npc !== 32'h3000) begin bad++; $display("FAIL rst_npc got=%h exp=%h", bus.npc, 32'h3000); end
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%b exp=0", bus.pc_en); end
    total++; if (bus.ifid_en !== 1'b0) begin bad++; $display("FAIL rst_ifid_en got=%b exp=0", bus.ifid_en); end
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b exp=0", bus.addr_err); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", bus.stall_cnt); end
    @(negedge clk); reset = 1'b1; #1;
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL boot_pc_en got=%b exp=0", bus.pc_en); end
    total++; if (bus.npc !== 32'h3000) begin bad++; $display("FAIL boot_npc got=%h exp=%h", bus.npc, 32'h3000); end
    @(negedge clk); #1;
    total++; if (bus.pc_cur !== 32'h3000) begin bad++; $display("FAIL seq0_pc got=%h exp=%h", bus.pc_cur, 32'h3000); end
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL seq0_pc_en got=%b exp=1", bus.pc_en); end
    total++; if (bus.npc !== 32'h3004) begin bad++; $display("FAIL seq0_npc got=%h exp=%h", bus.npc, 32'h3004); end
    @(negedge clk); #1;
    total++; if (bus.pc_cur !== 32'h3004) begin bad++; $display("FAIL seq1_pc got=%h exp=%h", bus.pc_cur, 32'h3004); end
    @(negedge clk); #1;
    total++; if (bus.pc_cur !== 32'h3008) begin bad++; $display("FAIL seq2_pc got=%h exp=%h", bus.pc_cur, 32'h3008); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL seq_cnt got=%h exp=0", bus.stall_cnt); end
  endtask

  task automatic test_redirect();
    int n = 0;
    while (bus.pc_cur !== 32'h3010 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    total++; if (bus.pc_cur !== 32'h3010) begin bad++; $display("FAIL reach_3010 got=%h exp=%h", bus.pc_cur, 32'h3010); end
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3040; #1;
    total++; if (bus.npc !== 32'h3040) begin bad++; $display("FAIL br_npc got=%h exp=%h", bus.npc, 32'h3040); end
    total++; if (bus.ifid_en !== 1'b1) begin bad++; $display("FAIL br_ifid got=%b exp=1", bus.ifid_en); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    total++; if (bus.pc_cur !== 32'h3040) begin bad++; $display("FAIL br_pc got=%h exp=%h", bus.pc_cur, 32'h3040); end
    total++; if (bus.ifid_en !== 1'b1) begin bad++; $display("FAIL br_ifid2 got=%b exp=1", bus.ifid_en); end
  endtask

  task automatic test_imem_wait();
    logic [31:0] hold;
    int n = 0;
    @(negedge clk);
    bus.imem_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3100; #1;
    hold = pc_reg;
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL w_pc_en got=%b exp=0", bus.pc_en); end
    total++; if (bus.ifid_en !== 1'b0) begin bad++; $display("FAIL w_ifid got=%b exp=0", bus.ifid_en); end
    total++; if (bus.npc !== 32'h3100) begin bad++; $display("FAIL w_live_npc got=%h exp=%h", bus.npc, 32'h3100); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.redirect_valid = 1'b0; #1;
      total++; if (bus.npc !== 32'h3100) begin bad++; $display("FAIL w_buf_npc got=%h exp=%h", bus.npc, 32'h3100); end
      total++; if (bus.pc_cur !== hold) begin bad++; $display("FAIL w_hold got=%h exp=%h", bus.pc_cur, hold); end
    end
    @(negedge clk); bus.imem_ready = 1'b1; #1;
    total++; if (bus.stall_cnt !== 16'd3) begin bad++; $display("FAIL w_cnt got=%h exp=3", bus.stall_cnt); end
    while (bus.pc_en !== 1'b1 && n < 4) begin
      @(negedge clk); #1; n++;
    end
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL w_resume got=%b exp=1", bus.pc_en); end
    total++; if (bus.npc !== 32'h3100) begin bad++; $display("FAIL w_use_npc got=%h exp=%h", bus.npc, 32'h3100); end
    @(negedge clk); #1;
    total++; if (bus.pc_cur !== 32'h3100) begin bad++; $display("FAIL w_pc got=%h exp=%h", bus.pc_cur, 32'h3100); end
    total++; if (bus.npc !== 32'h3104) begin bad++; $display("FAIL w_clr_npc got=%h exp=%h", bus.npc, 32'h3104); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3200; #1;
      total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL st_pc_en got=%b exp=0", bus.pc_en); end
      total++; if (bus.ifid_en !== 1'b0) begin bad++; $display("FAIL st_ifid got=%b exp=0", bus.ifid_en); end
      total++; if (bus.npc !== 32'h3108) begin bad++; $display("FAIL st_npc got=%h exp=%h", bus.npc, 32'h3108); end
    end
    @(negedge clk); bus.stall = 1'b0; #1;
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL st_rel_pc_en got=%b exp=1", bus.pc_en); end
    total++; if (bus.npc !== 32'h3200) begin bad++; $display("FAIL st_rel_npc got=%h exp=%h", bus.npc, 32'h3200); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    total++; if (bus.pc_cur !== 32'h3200) begin bad++; $display("FAIL st_pc got=%h exp=%h", bus.pc_cur, 32'h3200); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3042; #1;
    total++; if (bus.addr_err !== 1'b1) begin bad++; $display("FAIL ma_err got=%b exp=1", bus.addr_err); end
    total++; if (bus.npc !== 32'h3040) begin bad++; $display("FAIL ma_npc got=%h exp=%h", bus.npc, 32'h3040); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL ma_err_off got=%b exp=0", bus.addr_err); end
    total++; if (bus.pc_cur !== 32'h3040) begin bad++; $display("FAIL ma_pc got=%h exp=%h", bus.pc_cur, 32'h3040); end
  endtask

  task automatic test_wrap_saturate();
    @(negedge clk);
    bus.stall = 1'b1; ovr_en = 1'b1; ovr_pc = 32'hFFFF_FFFC; #1;
    total++; if (bus.npc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%h exp=0", bus.npc); end
    @(negedge clk); ovr_en = 1'b0;
    repeat (70000) @(negedge clk);
    #1;
    total++; if (bus.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h exp=ffff", bus.stall_cnt); end
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL sat_pc_en got=%b exp=0", bus.pc_en); end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    bus.stall = 1'b0; bus.imem_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3300; #1;
    total++; if (bus.npc !== 32'h3300) begin bad++; $display("FAIL rw_live got=%h exp=%h", bus.npc, 32'h3300); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    total++; if (bus.npc !== 32'h3300) begin bad++; $display("FAIL rw_buf got=%h exp=%h", bus.npc, 32'h3300); end
    @(negedge clk); reset = 1'b0; #1;
    total++; if (bus.npc !== 32'h3000) begin bad++; $display("FAIL rw_rst_npc got=%h exp=%h", bus.npc, 32'h3000); end
    @(negedge clk); reset = 1'b1; bus.imem_ready = 1'b1; #1;
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL rw_cnt got=%h exp=0", bus.stall_cnt); end
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL rw_boot got=%b exp=0", bus.pc_en); end
    @(negedge clk); #1;
    total++; if (bus.pc_cur !== 32'h3000) begin bad++; $display("FAIL rw_pc got=%h exp=%h", bus.pc_cur, 32'h3000); end
    total++; if (bus.npc !== 32'h3004) begin bad++; $display("FAIL rw_npc got=%h exp=%h", bus.npc, 32'h3004); end
  endtask

  initial begin
    reset = 1'b0;
    ovr_en = 1'b0;
    ovr_pc = '0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.imem_ready = 1'b1;
    test_reset();
    test_redirect();
    test_imem_wait();
    test_stall();
    test_misalign();
    test_wrap_saturate();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
